// File: rtl/rv_pkg.sv
// Shared RISC-V execute-stage definitions: ALU operation encodings,
// datapath/register-index widths and the EX operand-stage entry payload.
package rv_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned ALU_SEL_W  = 4;

  typedef enum logic [ALU_SEL_W-1:0] {
    ALU_ADD   = 4'b0000,
    ALU_SLL   = 4'b0001,
    ALU_SLT   = 4'b0010,
    ALU_SLTU  = 4'b0011,
    ALU_XOR   = 4'b0100,
    ALU_SRL   = 4'b0101,
    ALU_OR    = 4'b0110,
    ALU_AND   = 4'b0111,
    ALU_SUB   = 4'b1000,
    ALU_PASSB = 4'b1001,
    ALU_SRA   = 4'b1101
  } alu_sel_e;

  // One decoded instruction as held by the operand stage.
  typedef struct packed {
    logic [XLEN-1:0]       pc;
    logic [REG_ADDR_W-1:0] rs1_addr;
    logic [REG_ADDR_W-1:0] rs2_addr;
    logic [XLEN-1:0]       rs1_data;
    logic [XLEN-1:0]       rs2_data;
    logic [XLEN-1:0]       imm;
    logic [REG_ADDR_W-1:0] rd_addr;
    logic                  reg_we;
    logic [ALU_SEL_W-1:0]  alu_sel;
    logic                  a_pc;
    logic                  b_imm;
  } ex_entry_t;

endpackage

// File: rtl/fwd_mux.sv
// Operand forwarding select for one source register.
// Ports: rs_addr/rs_data (stored index and value), mem_* (EX/MEM source),
// wb_* (MEM/WB source), data_c (forwarded operand, combinational).
// Priority: x0 -> 0, then EX/MEM (non-load only), then MEM/WB, then stored.
module fwd_mux
  import rv_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] rs_addr,
  input  logic [XLEN-1:0]       rs_data,
  input  logic                  mem_we,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic [XLEN-1:0]       mem_data,
  input  logic                  mem_is_load,
  input  logic                  wb_we,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic [XLEN-1:0]       wb_data,
  output logic [XLEN-1:0]       data_c
);

  always_comb begin
    data_c = rs_data;
    if (rs_addr == '0) begin
      data_c = '0;
    end else if (mem_we && (mem_rd == rs_addr) && !mem_is_load) begin
      data_c = mem_data;
    end else if (wb_we && (wb_rd == rs_addr)) begin
      data_c = wb_data;
    end
  end

endmodule

// File: rtl/ex_operand_stage.sv
// Single-entry EX operand stage: captures a decoded instruction, forwards
// register operands from EX/MEM and MEM/WB, bubbles on load-use hazards.
// Ports: clk/rst; id_* decode offer with id_valid/id_ready handshake;
// flush kills held and offered instruction; mem_*/wb_* forwarding sources;
// ex_valid/ex_ready downstream handshake with alu_inA/alu_inB/alu_sel and
// ex_rd_addr/ex_reg_we/ex_pc sideband.
module ex_operand_stage
  import rv_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  output logic                  id_ready,
  input  logic [XLEN-1:0]       id_pc,
  input  logic [REG_ADDR_W-1:0] id_rs1_addr,
  input  logic [REG_ADDR_W-1:0] id_rs2_addr,
  input  logic [XLEN-1:0]       id_rs1_data,
  input  logic [XLEN-1:0]       id_rs2_data,
  input  logic [XLEN-1:0]       id_imm,
  input  logic [REG_ADDR_W-1:0] id_rd_addr,
  input  logic                  id_reg_we,
  input  logic [ALU_SEL_W-1:0]  id_alu_sel,
  input  logic                  id_a_pc,
  input  logic                  id_b_imm,
  input  logic                  flush,
  input  logic                  mem_we,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic [XLEN-1:0]       mem_data,
  input  logic                  mem_is_load,
  input  logic                  wb_we,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic [XLEN-1:0]       wb_data,
  output logic                  ex_valid,
  input  logic                  ex_ready,
  output logic [XLEN-1:0]       alu_inA,
  output logic [XLEN-1:0]       alu_inB,
  output logic [ALU_SEL_W-1:0]  alu_sel,
  output logic [REG_ADDR_W-1:0] ex_rd_addr,
  output logic                  ex_reg_we,
  output logic [XLEN-1:0]       ex_pc
);

  logic            full_q;
  ex_entry_t       entry_q;
  ex_entry_t       new_entry_c;
  logic [XLEN-1:0] fwd_rs1_c;
  logic [XLEN-1:0] fwd_rs2_c;
  logic            hazard_c;
  logic            drain_c;
  logic            capture_c;

  fwd_mux u_fwd_rs1 (
    .rs_addr     (entry_q.rs1_addr),
    .rs_data     (entry_q.rs1_data),
    .mem_we      (mem_we),
    .mem_rd      (mem_rd),
    .mem_data    (mem_data),
    .mem_is_load (mem_is_load),
    .wb_we       (wb_we),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .data_c      (fwd_rs1_c)
  );

  fwd_mux u_fwd_rs2 (
    .rs_addr     (entry_q.rs2_addr),
    .rs_data     (entry_q.rs2_data),
    .mem_we      (mem_we),
    .mem_rd      (mem_rd),
    .mem_data    (mem_data),
    .mem_is_load (mem_is_load),
    .wb_we       (wb_we),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .data_c      (fwd_rs2_c)
  );

  // Load-use hazard only counts sources the ALU actually consumes.
  always_comb begin
    hazard_c = 1'b0;
    if (full_q && mem_we && mem_is_load && (mem_rd != '0)) begin
      hazard_c = (!entry_q.a_pc  && (mem_rd == entry_q.rs1_addr)) ||
                 (!entry_q.b_imm && (mem_rd == entry_q.rs2_addr));
    end
  end

  // Handshake: pass-through capture allowed in the cycle the entry drains.
  always_comb begin
    ex_valid  = full_q && !hazard_c && !flush;
    drain_c   = ex_valid && ex_ready;
    id_ready  = !full_q || drain_c;
    capture_c = id_valid && id_ready && !flush;
  end

  always_comb begin
    new_entry_c          = '0;
    new_entry_c.pc       = id_pc;
    new_entry_c.rs1_addr = id_rs1_addr;
    new_entry_c.rs2_addr = id_rs2_addr;
    new_entry_c.rs1_data = id_rs1_data;
    new_entry_c.rs2_data = id_rs2_data;
    new_entry_c.imm      = id_imm;
    new_entry_c.rd_addr  = id_rd_addr;
    new_entry_c.reg_we   = id_reg_we;
    new_entry_c.alu_sel  = id_alu_sel;
    new_entry_c.a_pc     = id_a_pc;
    new_entry_c.b_imm    = id_b_imm;
  end

  // Entry register; a held entry absorbs forwarded values so it survives
  // the forwarding source retiring before it drains.
  always_ff @(posedge clk) begin
    if (rst) begin
      full_q  <= 1'b0;
      entry_q <= '0;
    end else if (flush) begin
      full_q <= 1'b0;
    end else if (capture_c) begin
      full_q  <= 1'b1;
      entry_q <= new_entry_c;
    end else if (drain_c) begin
      full_q <= 1'b0;
    end else if (full_q) begin
      entry_q.rs1_data <= fwd_rs1_c;
      entry_q.rs2_data <= fwd_rs2_c;
    end
  end

  always_comb begin
    alu_inA    = entry_q.a_pc  ? entry_q.pc  : fwd_rs1_c;
    alu_inB    = entry_q.b_imm ? entry_q.imm : fwd_rs2_c;
    alu_sel    = entry_q.alu_sel;
    ex_rd_addr = entry_q.rd_addr;
    ex_reg_we  = entry_q.reg_we;
    ex_pc      = entry_q.pc;
  end

endmodule

// File: doc/ex_operand_stage.md
EX_OPERAND_STAGE -- requirements
Module: ex_operand_stage

Interface
REQ-001 The block SHALL have one clock, clk, and a synchronous, active-high reset, rst; all state SHALL update on the rising edge of clk.
REQ-002 Ports, clock and reset first, given as name direction width meaning:
- clk in 1: clock
- rst in 1: synchronous active-high reset
- id_valid in 1: decode offers an instruction
- id_ready out 1: stage accepts the offer
- id_pc in 32: PC of the instruction
- id_rs1_addr, id_rs2_addr in 5 each: source register indices
- id_rs1_data, id_rs2_data in 32 each: register-file read data
- id_imm in 32: sign-extended immediate
- id_rd_addr in 5: destination register index
- id_reg_we in 1: instruction writes rd
- id_alu_sel in 4: ALU operation code
- id_a_pc in 1: operand A is the PC
- id_b_imm in 1: operand B is the immediate
- flush in 1: kill the held and offered instruction
- mem_we, mem_rd, mem_data, mem_is_load in 1/5/32/1: EX/MEM forwarding source
- wb_we, wb_rd, wb_data in 1/5/32: MEM/WB forwarding source
- ex_valid out 1: ALU operands are valid
- ex_ready in 1: downstream accepts
- alu_inA, alu_inB out 32 each: ALU operands
- alu_sel out 4: ALU operation
- ex_rd_addr out 5, ex_reg_we out 1, ex_pc out 32: sideband carried with the operands

Function
REQ-003 The stage SHALL hold one entry: a full bit plus all id_* fields.
REQ-004 A handshake SHALL complete on a cycle with id_valid && id_ready; it SHALL complete on ex_valid && ex_ready downstream.
REQ-005 id_ready SHALL be 1 when !full, or when ex_valid && ex_ready (pass-through capture in the same cycle as drain).
REQ-006 A captured entry SHALL appear on the outputs the cycle after capture (latency 1); the stage SHALL sustain throughput of 1 per cycle.
REQ-007 Forwarded rsN value SHALL be chosen with mem priority over wb over the stored value:
- mem_data if mem_we && mem_rd==rsN && rsN!=0 && !mem_is_load
- else wb_data if wb_we && wb_rd==rsN && rsN!=0
- else stored rsN data
REQ-008 Register x0 SHALL always yield 32'd0, regardless of stored data or forwarding sources.
REQ-009 Load-use hazard SHALL hold when full && mem_we && mem_is_load && mem_rd!=0 && mem_rd matches a *used* source (rs1 if !a_pc; rs2 if !b_imm); while the hazard holds, ex_valid SHALL be 0 and the entry SHALL be held (bubble).
REQ-010 ex_valid SHALL be full && !hazard && !flush.
REQ-011 alu_inA SHALL be stored pc when a_pc, else forwarded rs1.
REQ-012 alu_inB SHALL be stored imm when b_imm, else forwarded rs2.
REQ-013 alu_sel, ex_rd_addr, ex_reg_we and ex_pc SHALL reflect the stored entry.
REQ-014 While an entry is held (not drained), each cycle's stored rs1/rs2 data SHALL be overwritten by the REQ-007 forwarded value, so that the operands remain correct after forwarding sources retire.
REQ-015 flush SHALL clear full at the next edge and block capture that cycle; flush SHALL win over a simultaneous capture.
REQ-016 The hazard SHALL be evaluated every cycle; a bubble SHALL last until mem_is_load drops or mem_rd changes, with no internal counter.

Reset
REQ-017 On rst the block SHALL clear full. All outputs SHALL then read 0, except id_ready=1. Stored fields SHALL reset to 0. rst SHALL override flush, capture and drain.

Structure
REQ-018 Package rv_pkg SHALL hold the alu_sel encodings (ADD 0000, SUB 1000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, OR 0110, AND 0111, PASSB 1001, SRA 1101) and the register-index width constant (5).
REQ-019 The forwarding selection of REQ-007/REQ-008 SHALL be a sub-module fwd_mux, instantiated once per source operand.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Back-to-back ADD x3=x1+x2 (rs1=5, rs2=7), then ADD x4=x3+x3 with mem_we=1, mem_rd=3, mem_data=12 -> second issue gives alu_inA=alu_inB=12, no bubble.
- Load-use: mem_is_load=1, mem_rd=3; held instruction reads x3 -> ex_valid=0 for 1 cycle; next cycle wb_rd=3, wb_data=0xDEAD -> ex_valid=1, alu_inA=0xDEAD; 0xDEAD retained after wb retires.
- rs1=0, stored 0xFFFF_FFFF, mem_rd=0 with mem_we=1 -> alu_inA=0.
- ex_ready=0 for 3 cycles with id_valid=1 -> entry held, id_ready=0; ex_ready=1 -> drain and capture in the same cycle.
- flush with id_valid=1 and full=1 -> next cycle ex_valid=0 and the new instruction is not captured.
- rst asserted mid-stall -> next cycle ex_valid=0, id_ready=1, alu_inA=0.
